tt_um_seq_divider_hhrb98: RTL

Sequential unsigned restoring divider. It is the inverse operation of the team's combinational 4x4 Booth multiplier tile: an 8-bit dividend divided by a 4-bit divisor yields an 8-bit quotient and a 4-bit remainder. The block sits in the standard tile wrapper and produces one quotient bit per clock. It uses a start/busy/done handshake so software or a bench can check a multiplier product by dividing it back.

---
 rtl/tt_um_seq_divider_hhrb98.sv | 119 +++++++++++
 1 files changed

// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential unsigned restoring divider: DVD_W-bit dividend / DVS_W-bit divisor,
// one quotient bit per enabled clock, start/busy/done handshake on uio.
module tt_um_seq_divider_hhrb98 #(
   parameter int DVD_W = 8,
   parameter int DVS_W = 4
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int CNT_W = $clog2(DVD_W + 1);

   logic [1:0]       state;
   logic             start_q;
   logic [DVD_W-1:0] dvd;
   logic [DVD_W-1:0] quo;
   logic [DVS_W-1:0] dvs;
   logic [DVS_W-1:0] rem;
   logic [DVS_W:0]   p;
   logic [CNT_W-1:0] cnt;
   logic             div0;
   logic             busy;
   logic             done;

   logic             start_in;
   logic             sel;
   logic             accept;
   logic [DVS_W:0]   p_shift;
   logic [DVS_W:0]   p_next;
   logic             q_bit;
   logic [DVD_W-1:0] rem_word;
   logic             unused_uio;

   assign start_in   = uio_in[4];
   assign sel        = uio_in[5];
   assign unused_uio = &{1'b0, uio_in[7:6]};
   assign accept     = start_in && !start_q && (state != ST_RUN);

   always_comb begin
      p_shift = {p[DVS_W-1:0], dvd[DVD_W-1]};
      p_next  = p_shift;
      q_bit   = 1'b0;
      if (p_shift >= {1'b0, dvs}) begin
         p_next = p_shift - {1'b0, dvs};
         q_bit  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         start_q <= 1'b0;
         dvd     <= '0;
         dvs     <= '0;
         quo     <= '0;
         rem     <= '0;
         p       <= '0;
         cnt     <= '0;
         div0    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (ena) begin
         start_q <= start_in;
         if (accept) begin
            dvd   <= ui_in[DVD_W-1:0];
            dvs   <= uio_in[DVS_W-1:0];
            quo   <= '0;
            rem   <= '0;
            p     <= '0;
            cnt   <= '0;
            div0  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_RUN;
         end else if (state == ST_RUN) begin
            // Zero divisor passes through RUN for one cycle so results land at t+1.
            if (dvs == '0) begin
               quo   <= '1;
               rem   <= dvd[DVS_W-1:0];
               div0  <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_DONE;
            end else begin
               p   <= p_next;
               dvd <= {dvd[DVD_W-2:0], 1'b0};
               quo <= {quo[DVD_W-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DVD_W - 1)) begin
                  rem   <= p_next[DVS_W-1:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
         end
      end
   end

   always_comb begin
      rem_word              = '0;
      rem_word[DVS_W-1:0]   = rem;
      rem_word[DVD_W-1]     = div0;
   end

   assign uo_out  = sel ? rem_word : quo;
   assign uio_out = {done, busy, 6'b00_0000};
   assign uio_oe  = 8'b1100_0000;

endmodule
